// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the EX-stage multiply/divide unit.
//   - RV32M funct3 encodings
//   - FSM state encoding
//   - two's-complement negate helper
package ex_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    // Widest operand the negate helper handles (covers 2*XLEN up to XLEN=64).
    localparam int NEG_W = 128;

    // Low bits of a negation depend only on the low bits of the input, so
    // callers zero-extend to NEG_W and size-cast the result back down.
    function automatic logic [NEG_W-1:0] twos_neg(input logic [NEG_W-1:0] v);
        return ~v + NEG_W'(1);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the iterative mul/div.
//   is_div_i : 1 = restoring-divide step, 0 = shift-add multiply step
//   a_i      : multiplicand (mul) or divisor (div) magnitude
//   p_i      : partial register; mul {acc, multiplier}, div {rem, dividend/quotient}
//   p_o      : partial register after this step
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [2*XLEN-1:0] p_i,
    output logic [2*XLEN-1:0] p_o
);

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_p;
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   diff;
    logic              borrow;
    logic [2*XLEN-1:0] div_p;

    always_comb begin
        // Multiply: add multiplicand into upper half when LSB set, then shift right
        // keeping the carry as the new top bit.
        mul_sum = {1'b0, p_i[2*XLEN-1:XLEN]} + (p_i[0] ? {1'b0, a_i} : '0);
        mul_p   = {mul_sum, p_i[XLEN-1:1]};

        // Divide: shift next dividend bit into the remainder and trial-subtract.
        // When no borrow the true difference is < divisor, so XLEN bits suffice.
        rem_sh = p_i[2*XLEN-1:XLEN-1];
        borrow = rem_sh < {1'b0, a_i};
        diff   = rem_sh[XLEN-1:0] - a_i;
        if (borrow)
            div_p = {rem_sh[XLEN-1:0], p_i[XLEN-2:0], 1'b0};
        else
            div_p = {diff, p_i[XLEN-2:0], 1'b1};

        p_o = is_div_i ? div_p : mul_p;
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide beside the EX-stage ALU.
//   CLK, RESET            : clock, synchronous active-high reset
//   START, FLUSH          : op request (IDLE only) / kill in-flight op
//   FUNC3, OP1, OP2       : M-extension funct3 and forwarded operands
//   RD_ADDR_IN            : destination register of the op
//   BUSY, STALL_REQ       : unit occupied / pipeline stall request
//   DONE                  : one-cycle pulse, RESULT and RD_ADDR_OUT valid
//   RESULT, RD_ADDR_OUT   : registered result and destination, held until next DONE
module ex_muldiv_unit
    import ex_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic               FLUSH,
    input  logic [2:0]         FUNC3,
    input  logic [XLEN-1:0]    OP1,
    input  logic [XLEN-1:0]    OP2,
    input  logic [RADDR_W-1:0] RD_ADDR_IN,
    output logic               BUSY,
    output logic               STALL_REQ,
    output logic               DONE,
    output logic [XLEN-1:0]    RESULT,
    output logic [RADDR_W-1:0] RD_ADDR_OUT
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam int PW    = 2 * XLEN;

    state_t             state_q;
    logic [2:0]         func3_q;
    logic [RADDR_W-1:0] rd_q;
    logic [XLEN-1:0]    a_q;
    logic [PW-1:0]      p_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;
    logic               done_q;
    logic [XLEN-1:0]    result_q;
    logic [RADDR_W-1:0] rd_out_q;

    // Capture-side decode of the incoming op
    logic            sgn1, sgn2, op1_neg, op2_neg, is_div_in, is_rem_in;
    logic            div_zero, div_ovf, res_neg_in;
    logic [XLEN-1:0] mag1, mag2;
    logic [PW-1:0]   p_load;
    logic [XLEN-1:0] a_load;

    always_comb begin
        is_div_in = FUNC3[2];
        is_rem_in = FUNC3[2] & FUNC3[1];
        sgn1      = !(FUNC3 == F3_MULHU || FUNC3 == F3_DIVU || FUNC3 == F3_REMU);
        sgn2      = (FUNC3 == F3_MUL || FUNC3 == F3_MULH || FUNC3 == F3_DIV || FUNC3 == F3_REM);
        op1_neg   = sgn1 & OP1[XLEN-1];
        op2_neg   = sgn2 & OP2[XLEN-1];
        mag1      = op1_neg ? XLEN'(twos_neg(NEG_W'(OP1))) : OP1;
        mag2      = op2_neg ? XLEN'(twos_neg(NEG_W'(OP2))) : OP2;
        // Remainder follows the dividend; everything else takes the product/quotient sign.
        res_neg_in = is_rem_in ? op1_neg : (op1_neg ^ op2_neg);
        div_zero   = is_div_in && (OP2 == '0);
        div_ovf    = (FUNC3 == F3_DIV || FUNC3 == F3_REM) &&
                     (OP1 == {1'b1, {(XLEN-1){1'b0}}}) && (OP2 == '1);

        // Special cases preload p_q so FINISH's normal select yields the answer
        // with no sign fix: {rem, quo} = {OP1, all-ones} or {0, OP1}.
        a_load = is_div_in ? mag2 : mag1;
        if (div_zero)
            p_load = {OP1, {XLEN{1'b1}}};
        else if (div_ovf)
            p_load = {{XLEN{1'b0}}, OP1};
        else if (is_div_in)
            p_load = {{XLEN{1'b0}}, mag1};
        else
            p_load = {{XLEN{1'b0}}, mag2};
    end

    logic [PW-1:0] p_step;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i (func3_q[2]),
        .a_i      (a_q),
        .p_i      (p_q),
        .p_o      (p_step)
    );

    // Result selection and sign fix in FINISH
    logic [PW-1:0]   prod_fix;
    logic [XLEN-1:0] quo, rem, fin_res;

    always_comb begin
        prod_fix = neg_q ? PW'(twos_neg(NEG_W'(p_q))) : p_q;
        quo      = p_q[XLEN-1:0];
        rem      = p_q[PW-1:XLEN];
        if (!func3_q[2])
            fin_res = (func3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN];
        else if (func3_q[1])
            fin_res = neg_q ? XLEN'(twos_neg(NEG_W'(rem))) : rem;
        else
            fin_res = neg_q ? XLEN'(twos_neg(NEG_W'(quo))) : quo;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            func3_q  <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (START && !FLUSH) begin
                        func3_q <= FUNC3;
                        rd_q    <= RD_ADDR_IN;
                        a_q     <= a_load;
                        p_q     <= p_load;
                        neg_q   <= (div_zero || div_ovf) ? 1'b0 : res_neg_in;
                        cnt_q   <= CNT_W'(XLEN);
                        state_q <= (div_zero || div_ovf) ? S_FINISH : S_CALC;
                    end
                end
                S_CALC: begin
                    if (FLUSH) begin
                        state_q <= S_IDLE;
                    end else begin
                        p_q   <= p_step;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1))
                            state_q <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                    if (!FLUSH) begin
                        result_q <= fin_res;
                        rd_out_q <= rd_q;
                        done_q   <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign BUSY        = (state_q != S_IDLE);
    assign STALL_REQ   = BUSY | (START & ~FLUSH);
    assign DONE        = done_q;
    assign RESULT      = result_q;
    assign RD_ADDR_OUT = rd_out_q;

endmodule
